// File: rtl/matrix_calculator_writeval.sv
// Avalon-MM slave feeding a small streaming FIFO: pushes via DATA writes,
// drains on out_valid/out_ready, and exposes status and a transfer counter.
module matrix_calculator_writeval #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_XFERCNT = 2'd3;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic [15:0]           xfer_cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic push_ok;
    logic flush;
    logic clr_ovf;
    logic clr_xfer;

    // Only the low bits of writedata are meaningful; fold the rest away.
    wire unused_wdata = ^writedata;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_data  = out_valid ? mem[head] : '0;

    assign push     = write && (address == ADDR_DATA);
    assign flush    = write && (address == ADDR_CONTROL) && writedata[0];
    assign clr_ovf  = write && (address == ADDR_CONTROL) && writedata[1];
    assign clr_xfer = write && (address == ADDR_XFERCNT);
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= writedata[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push_ok) begin
                tail <= tail + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Flush suppresses the pop, so it is not counted either.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_cnt <= '0;
        end else if (clr_xfer) begin
            xfer_cnt <= '0;
        end else if (pop && !flush) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA:    readdata <= 32'(out_data);
                ADDR_STATUS:  readdata <= {21'b0, overflow, full, empty, 3'b0, 5'(count)};
                ADDR_CONTROL: readdata <= '0;
                ADDR_XFERCNT: readdata <= {16'b0, xfer_cnt};
                default:      readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_calculator_writeval.sv
// Directed bench for matrix_calculator_writeval with hand-computed expectations.
module tb_matrix_calculator_writeval;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int total;
    int bad;

    matrix_calculator_writeval #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] v);
        write = 1'b1; address = 2'd0; writedata = v;
        tick();
        write = 1'b0;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] v);
        write = 1'b1; address = a; writedata = v;
        tick();
        write = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] v);
        write = 1'b0; address = a;
        tick();
        v = readdata;
    endtask

    logic [31:0] rv;
    logic [7:0]  exp_seq [4];

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; address = 2'd0; write = 1'b0; writedata = '0; out_ready = 1'b0;
        tick(); tick();
        check_val("rst_readdata", readdata, 32'h0);
        check_val("rst_out_valid", 32'(out_valid), 32'h0);
        check_val("rst_out_data", 32'(out_data), 32'h0);
        reset_n = 1'b1;

        // Fill to full, fifth push overflows
        push(32'h11); push(32'h22); push(32'h33); push(32'h44); push(32'h55);
        reg_rd(2'd1, rv);
        check_val("status_full_ovf", rv, 32'h604);
        check_val("head_after_fill", 32'(out_data), 32'h11);
        reg_rd(2'd0, rv);
        check_val("data_read_head", rv, 32'h11);

        // Drain four
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("drain_%0d", i), 32'(out_data), 32'(exp_seq[i]));
            tick();
        end
        out_ready = 1'b0;
        check_val("drained_valid", 32'(out_valid), 32'h0);
        check_val("drained_data", 32'(out_data), 32'h0);
        reg_rd(2'd3, rv);
        check_val("xfercnt_4", rv, 32'h4);
        reg_rd(2'd1, rv);
        check_val("status_empty_ovf", rv, 32'h500);
        reg_wr(2'd2, 32'h2);
        reg_rd(2'd1, rv);
        check_val("status_ovf_cleared", rv, 32'h100);

        // Full + push + pop in one cycle
        push(32'hA1); push(32'hA2); push(32'hA3); push(32'hA4);
        out_ready = 1'b1;
        write = 1'b1; address = 2'd0; writedata = 32'h99;
        tick();
        write = 1'b0; out_ready = 1'b0;
        reg_rd(2'd1, rv);
        check_val("status_full_no_ovf", rv, 32'h204);
        exp_seq = '{8'hA2, 8'hA3, 8'hA4, 8'h99};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("fullpp_%0d", i), 32'(out_data), 32'(exp_seq[i]));
            tick();
        end
        out_ready = 1'b0;
        reg_rd(2'd3, rv);
        check_val("xfercnt_9", rv, 32'h9);

        // Flush + clear overflow with coincident pop
        push(32'hB1); push(32'hB2); push(32'hB3); push(32'hB4); push(32'hB5);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        reg_rd(2'd1, rv);
        check_val("status_cnt3_ovf", rv, 32'h403);
        out_ready = 1'b1;
        reg_wr(2'd2, 32'h3);
        out_ready = 1'b0;
        check_val("flush_valid", 32'(out_valid), 32'h0);
        reg_rd(2'd1, rv);
        check_val("flush_status", rv, 32'h100);
        reg_rd(2'd3, rv);
        check_val("flush_xfercnt", rv, 32'hA);

        // STATUS writes ignored; push upper bits ignored
        reg_wr(2'd1, 32'hFFFF_FFFF);
        reg_rd(2'd1, rv);
        check_val("status_wr_ignored", rv, 32'h100);
        push(32'hABCD_EF12);
        reg_rd(2'd0, rv);
        check_val("push_low_bits", rv, 32'h12);

        // XFERCNT wrap: clear, then 65535 push+pop cycles, then one more pop
        reg_wr(2'd3, 32'h0);
        reg_rd(2'd3, rv);
        check_val("xfer_cleared", rv, 32'h0);
        write = 1'b1; address = 2'd0; writedata = 32'h5A; out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        write = 1'b0; out_ready = 1'b0;
        reg_rd(2'd3, rv);
        check_val("xfer_ffff", rv, 32'hFFFF);
        reg_rd(2'd1, rv);
        check_val("status_cnt1", rv, 32'h001);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        reg_rd(2'd3, rv);
        check_val("xfer_wrap", rv, 32'h0);

        // Asynchronous reset mid-stream
        push(32'h21); push(32'h22);
        reg_rd(2'd1, rv);
        check_val("pre_rst_status", rv, 32'h002);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'h0);
        check_val("async_rst_readdata", readdata, 32'h0);
        check_val("async_rst_data", 32'(out_data), 32'h0);
        tick();
        reset_n = 1'b1;
        reg_rd(2'd1, rv);
        check_val("post_rst_status", rv, 32'h100);
        reg_rd(2'd3, rv);
        check_val("post_rst_xfer", rv, 32'h0);
        push(32'h77);
        check_val("post_rst_push", 32'(out_data), 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_calculator_writeval.md
MATRIX_CALCULATOR_WRITEVAL -- requirements
Module: matrix_calculator_writeval

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each output value.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  2  Avalon-MM word address.
REQ-006 write  input  1  Avalon-MM write strobe.
REQ-007 writedata  input  32  Avalon-MM write data.
REQ-008 readdata  output  32  Avalon-MM read data, registered, read latency 1.
REQ-009 out_data  output  DATA_WIDTH  value at FIFO head.
REQ-010 out_valid  output  1  FIFO non-empty; out_data is valid.
REQ-011 out_ready  input  1  downstream consumer accepts out_data this cycle.

Function
REQ-012 Register map: 0 = DATA (W push / R head), 1 = STATUS (R), 2 = CONTROL (W), 3 = XFERCNT (R, W clears).
REQ-013 Push: write with address 0 writes writedata[DATA_WIDTH-1:0] at the tail and increments count; upper bits are ignored.
REQ-014 Push while full: data dropped; count unchanged; sticky overflow flag set.
REQ-015 Exception: full plus push plus pop in the same cycle: the push is accepted; count stays DEPTH; overflow is not set.
REQ-016 out_valid shall equal (count != 0), driven from registered state; no same-cycle bypass from push to out_valid.
REQ-017 out_data shall equal the head entry whenever out_valid is 1; it is 0 when empty.
REQ-018 Pop occurs when out_valid and out_ready are both 1: head pointer advances and count decrements.
REQ-019 Push and pop in the same cycle with 0 < count < DEPTH: both take effect; count unchanged.
REQ-020 Head and tail pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0; count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-021 CONTROL write bit0 = flush: pointers and count go to 0 next cycle.
REQ-022 Flush wins over a coincident pop; that pop does not count as a transfer.
REQ-023 CONTROL write bit1 = clear overflow; the flag is 0 next cycle.
REQ-024 Other CONTROL bits are ignored.
REQ-025 XFERCNT is a 16-bit counter that increments on each pop and wraps 0xFFFF to 0x0000.
REQ-026 Any write to address 3 clears XFERCNT to 0; a coincident pop is not counted.
REQ-027 readdata is updated every clock, independent of read strobe, from the address in that cycle:
- 0: zero-extended head entry
- 1: {21'b0, overflow[10], full[9], empty[8], 3'b0, count[4:0]}
- 2: 0
- 3: {16'b0, XFERCNT}
REQ-028 STATUS and DATA reads reflect pre-edge state; a write in cycle N is visible to a read issued in cycle N+1.
REQ-029 Writes to address 1 have no effect.

Reset
REQ-030 While reset_n is low, the following are 0: readdata, out_valid, out_data, count, both pointers, overflow, XFERCNT.
REQ-031 Reset asserted mid-operation discards FIFO contents immediately (asynchronously); out_valid drops without waiting for a clock edge.
REQ-032 FIFO storage contents need not be reset.
REQ-033 After reset release, the first rising edge may accept a push.

Verification
REQ-034 Scenario:
- stimulus: out_ready=0; push 0x11, 0x22, 0x33, 0x44, then 0x55
- response: STATUS = 0x604 (full, overflow, count 4); out_data = 0x11
REQ-035 Scenario:
- stimulus: from REQ-034 state, out_ready=1 for 4 cycles
- response: out_data sequence 0x11, 0x22, 0x33, 0x44; out_valid low after; XFERCNT = 4; STATUS = 0x500
REQ-036 Scenario:
- stimulus: full FIFO; out_ready=1; push 0x99 in the same cycle
- response: count stays 4; overflow stays 0; 0x99 emerges 4th after the current head
REQ-037 Scenario:
- stimulus: count 3, out_ready=1, CONTROL write 0x3
- response: next cycle count 0, out_valid 0, overflow 0; XFERCNT unchanged
REQ-038 Scenario:
- stimulus: preload XFERCNT to 0xFFFF via 65535 pops, then 1 more pop
- response: XFERCNT reads 0x0000
REQ-039 Scenario:
- stimulus: assert reset_n low mid-stream with count 2
- response: out_valid and readdata 0 immediately; after release, STATUS = 0x100
